plt_array: RTL and testbench
============================

Name: plt_array

Overview:
Multi-tree programmable logic tree (PLT) array. It holds M independent binary trees of 2-input LUT nodes, and all trees share one N-bit data input. The config memory loads either serially (bit counter and done flag) or in parallel via the scan chain, and reads back in test mode. Usage mode is a valid-qualified evaluation path with registered outputs, optionally pipelined per tree level. It is the parametrised successor of the single-tree PLT and sits in the same programmable-fabric test area.

Parameters:
N, 8, inputs per tree; power of two, >= 2
M, 2, number of trees / output bits
CFG_W, 4*(N-1)*M, derived localparam; total config bits
LEVELS, $clog2(N), derived localparam; tree depth

Ports:
clk  input  1  single clock, rising edge
clear  input  1  asynchronous, active-high reset
mode  input  2  00 CONFIG, 01 USAGE, 10 TEST, 11 IDLE
data_in  input  N  shared tree inputs
in_valid  input  1  data_in qualifier in USAGE
config_in  input  1  serial config bit
config_en  input  1  serial shift enable in CONFIG
scan_in  input  CFG_W  parallel config load value
scan_enable  input  1  parallel load (CONFIG) / readback enable (TEST)
out  output  M  one result bit per tree
out_valid  output  1  out qualifier
scan_out  output  CFG_W  config readback
config_done  output  1  config memory fully loaded

Behaviour:
- clear (async): cfg=0, bit_cnt=0, config_done=0, out=0, out_valid=0, all pipeline regs and valids=0, scan_out=0.
- Config layout:
  - Tree t occupies cfg[t*4*(N-1) +: 4*(N-1)].
  - Within a tree, nodes are numbered level by level from the leaves: level 0 has nodes 0..N/2-1, then level 1, up to the root (node N-2). Node n uses bits [4n+3:4n].
  - Level-0 node j takes a=data_in[2j], b=data_in[2j+1]. A level-L node j takes a=node(L-1, 2j) and b=node(L-1, 2j+1).
  - Node output = lut[{b,a}].
- CONFIG (00):
  - scan_enable=1: cfg<=scan_in in one cycle; bit_cnt<=CFG_W; config_done<=1. This takes priority over config_en.
  - Else config_en=1: cfg<={config_in, cfg[CFG_W-1:1]}. The first bit shifted lands at bit 0 after CFG_W shifts. bit_cnt increments, saturating at CFG_W.
  - config_done is registered: it equals (bit_cnt==CFG_W) and asserts the cycle after the CFG_W-th shift.
  - Shifting past CFG_W keeps shifting (oldest bit drops); config_done stays 1.
  - A transition into 00 from any other mode clears bit_cnt and config_done on that first cycle.
- USAGE (01):
  - cfg is frozen.
  - If config_done=0, in_valid is ignored and out_valid=0.
  - Otherwise, on in_valid=1: out<=eval(data_in) and out_valid<=1 one cycle later (latency 1). On in_valid=0: out_valid<=0 and out holds.
  - Back-to-back valid inputs sustain throughput of 1 per cycle.
- TEST (10): cfg frozen; scan_out=cfg (registered, 1-cycle latency) when scan_enable=1, else 0. In all other modes scan_out=0.
- IDLE (11): cfg frozen; out holds; out_valid and all pipeline valids clear next cycle.
- Leaving USAGE mid-stream: in-flight valids are flushed (cleared next cycle); out holds its last value.
- Mode and config changes take effect on the next rising edge. No combinational path from mode to out.

Optional Feature:
PLT_PIPE_EN
- Defined: a register sits after every tree level, with a matching valid shift chain. Latency is LEVELS cycles (3 for N=8), throughput 1 per cycle. Flush rules apply to every stage.
- Undefined: single output register; latency 1.

Test Plan:
- Reset: assert clear for 2 cycles mid-clock -> out=0, out_valid=0, config_done=0, scan_out=0 immediately, without waiting for an edge.
- Scan load/readback (N=8, M=2, CFG_W=56): mode=00, scan_enable=1, scan_in=56'hA5_C3F0_1234_5678 for 1 cycle -> config_done=1. Then mode=10, scan_enable=1 -> scan_out=56'hA5_C3F0_1234_5678 one cycle later.
- Serial load: re-enter mode 00 and shift 56 bits -> config_done=0 after 55 shifts and 1 the cycle after the 56th. Readback matches with the first-shifted bit at bit 0.
- Evaluation: configure tree0 all nodes 4'b1000 (AND) and tree1 all nodes 4'b1110 (OR), then mode=01 with in_valid=1:
  - data_in 8'hFF -> out=2'b11
  - 8'h01 -> out=2'b10
  - 8'h00 -> out=2'b00
  - Each result appears 1 cycle later (3 with PLT_PIPE_EN), with out_valid high for exactly the valid inputs.
- Unconfigured usage: after clear, mode=01, in_valid=1, data_in=8'hFF for 5 cycles -> out_valid stays 0, out stays 0.
- Flush: stream 4 valid inputs, then switch to mode=11 -> out_valid=0 next cycle and out holds its last value. Asserting clear mid-stream zeroes everything, including config_done.

Source files
------------

// File: rtl/plt_array_if.sv
`default_nettype none
// ============================================================================
// Module   : plt_array_if
// Brief    : Bus bundle for the PLT array. It carries the mode, data, config
//            and scan signals and the result signals.
// Revision : 1.0 - initial release
// ============================================================================
interface plt_array_if #(
  parameter int N = 8,
  parameter int M = 2
);
  localparam int CFG_W = 4 * (N - 1) * M;

  logic [1:0]       mode;
  logic [N-1:0]     data_in;
  logic             in_valid;
  logic             config_in;
  logic             config_en;
  logic [CFG_W-1:0] scan_in;
  logic             scan_enable;
  logic [M-1:0]     out;
  logic             out_valid;
  logic [CFG_W-1:0] scan_out;
  logic             config_done;

  // Driver side (test environment / fabric controller)
  modport master (
    output mode, data_in, in_valid, config_in, config_en, scan_in, scan_enable,
    input  out, out_valid, scan_out, config_done
  );

  // PLT array side
  modport slave (
    input  mode, data_in, in_valid, config_in, config_en, scan_in, scan_enable,
    output out, out_valid, scan_out, config_done
  );
endinterface
`default_nettype wire

// File: rtl/plt_array.sv
`default_nettype none
// ============================================================================
// Module   : plt_array
// Brief    : M independent binary trees of 2-input LUT nodes. All trees share
//            one N-bit input. The config memory loads serially or through the
//            scan port, and it reads back in TEST mode. USAGE mode evaluates
//            valid-qualified inputs into registered outputs.
//            Optional macro PLT_PIPE_EN adds a register after every tree level.
// Revision : 1.0 - initial release
// ============================================================================
module plt_array #(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic       clk,
  input  logic       clear,
  plt_array_if.slave bus
);
  localparam int CFG_W  = 4 * (N - 1) * M;
  localparam int LEVELS = $clog2(N);
  localparam int TREE_W = 4 * (N - 1);
  localparam int CNT_W  = $clog2(CFG_W + 1);
`ifdef PLT_PIPE_EN
  localparam int STAGES = LEVELS;
`else
  localparam int STAGES = 1;
`endif

  typedef enum logic [1:0] {
    MODE_CONFIG = 2'b00,
    MODE_USAGE  = 2'b01,
    MODE_TEST   = 2'b10,
    MODE_IDLE   = 2'b11
  } mode_t;

  mode_t              mode;
  mode_t              prev_mode;
  logic [CFG_W-1:0]   cfg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               config_done;
  logic [CFG_W-1:0]   scan_out;
  logic [M-1:0]       out_q;
  logic [STAGES-1:0]  vld;
  logic               usage;
  logic               accept;
`ifdef PLT_PIPE_EN
  logic [M*(N-1)-1:0] node_val;
  logic [M*(N-1)-1:0] node_reg;
  logic [LEVELS-1:0]  stage_en;
`else
  logic [M-1:0]       root_val;
`endif

  assign mode   = mode_t'(bus.mode);
  assign usage  = (mode == MODE_USAGE);
  assign accept = usage && config_done && bus.in_valid;

  // Config memory and load tracking. The cycle that enters CONFIG from
  // another mode restarts the bit count and does nothing else.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      prev_mode   <= MODE_CONFIG;
      cfg         <= '0;
      bit_cnt     <= '0;
      config_done <= 1'b0;
    end else begin
      prev_mode <= mode;
      if (mode == MODE_CONFIG) begin
        if (prev_mode != MODE_CONFIG) begin
          bit_cnt     <= '0;
          config_done <= 1'b0;
        end else if (bus.scan_enable) begin
          cfg         <= bus.scan_in;
          bit_cnt     <= CNT_W'(CFG_W);
          config_done <= 1'b1;
        end else if (bus.config_en) begin
          cfg <= {bus.config_in, cfg[CFG_W-1:1]};
          if (bit_cnt != CNT_W'(CFG_W)) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          config_done <= (bit_cnt >= CNT_W'(CFG_W - 1));
        end
      end
    end
  end

  // Readback port. Its value is non-zero only in TEST mode with scan_enable high.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      scan_out <= '0;
    end else begin
      scan_out <= (mode == MODE_TEST && bus.scan_enable) ? cfg : '0;
    end
  end

  // Valid chain. Any mode other than USAGE flushes every in-flight stage.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      vld <= '0;
    end else begin
      vld[0] <= accept;
      for (int s = 1; s < STAGES; s++) begin
        vld[s] <= usage && vld[s-1];
      end
    end
  end

  // LUT tree network. Level l starts at node index N - (N >> l).
  genvar t, l, j;
  generate
    for (t = 0; t < M; t++) begin : g_tree
      for (l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int BASE = N - (N >> l);
        for (j = 0; j < (N >> (l + 1)); j++) begin : g_node
          logic       a;
          logic       b;
          logic       y;
          logic [3:0] lut;
          assign lut = cfg[t*TREE_W + 4*(BASE + j) +: 4];
          if (l == 0) begin : g_leaf
            assign a = bus.data_in[2*j];
            assign b = bus.data_in[2*j + 1];
          end else begin : g_inner
`ifdef PLT_PIPE_EN
            localparam int PREV = N - (N >> (l - 1));
            assign a = node_reg[t*(N-1) + PREV + 2*j];
            assign b = node_reg[t*(N-1) + PREV + 2*j + 1];
`else
            assign a = g_lvl[l-1].g_node[2*j].y;
            assign b = g_lvl[l-1].g_node[2*j + 1].y;
`endif
          end
          assign y = lut[{b, a}];
`ifdef PLT_PIPE_EN
          assign node_val[t*(N-1) + BASE + j] = y;
`endif
        end
      end
`ifdef PLT_PIPE_EN
      assign out_q[t] = node_reg[t*(N-1) + N - 2];
`else
      assign root_val[t] = g_lvl[LEVELS-1].g_node[0].y;
`endif
    end
  endgenerate

`ifdef PLT_PIPE_EN
  function automatic int level_of(input int n);
    int lvl;
    lvl = 0;
    for (int k = 0; k < LEVELS; k++) begin
      if (n >= N - (N >> k)) lvl = k;
    end
    return lvl;
  endfunction

  assign stage_en[0] = accept;
  generate
    for (l = 1; l < LEVELS; l++) begin : g_stage_en
      assign stage_en[l] = usage && vld[l-1];
    end
  endgenerate

  // Per-level pipeline registers. A level loads only when a valid token
  // enters it, so the root register holds the last delivered result.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      node_reg <= '0;
    end else begin
      for (int tt = 0; tt < M; tt++) begin
        for (int n = 0; n < N - 1; n++) begin
          if (stage_en[level_of(n)]) begin
            node_reg[tt*(N-1) + n] <= node_val[tt*(N-1) + n];
          end
        end
      end
    end
  end
`else
  // Single result register. It holds its value when no input is accepted.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      out_q <= '0;
    end else if (accept) begin
      out_q <= root_val;
    end
  end
`endif

  assign bus.out         = out_q;
  assign bus.out_valid   = vld[STAGES-1];
  assign bus.scan_out    = scan_out;
  assign bus.config_done = config_done;

endmodule
`default_nettype wire

// File: tb/tb_plt_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_plt_array
// Brief    : Scoreboard bench for plt_array. It uses a tree-walking reference
//            model and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plt_array;
  localparam int N     = 8;
  localparam int M     = 2;
  localparam int CFG_W = 4 * (N - 1) * M;
  localparam int TW    = 4 * (N - 1);
`ifdef PLT_PIPE_EN
  localparam int LAT = $clog2(N);
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [M-1:0] val;
    int           due;
  } exp_t;

  logic clk;
  logic clear;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];
  logic [CFG_W-1:0] model_cfg;
  logic             model_done;
  logic [M-1:0]     last_out;

  plt_array_if #(.N(N), .M(M)) bus ();

  plt_array #(.N(N), .M(M)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: walk each tree level by level with plain arrays.
  function automatic logic [M-1:0] model_eval(input logic [CFG_W-1:0] c, input logic [N-1:0] d);
    logic [M-1:0] r;
    logic         v[N];
    logic [3:0]   lut;
    int           w;
    int           node;
    r = '0;
    for (int t = 0; t < M; t++) begin
      for (int i = 0; i < N; i++) v[i] = d[i];
      w    = N;
      node = 0;
      while (w > 1) begin
        for (int k = 0; k < w / 2; k++) begin
          lut  = c[t*TW + 4*node +: 4];
          v[k] = lut[{v[2*k+1], v[2*k]}];
          node = node + 1;
        end
        w = w / 2;
      end
      r[t] = v[0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one USAGE cycle. Predict the result only if the model says it is accepted.
  task automatic issue(input logic v, input logic [N-1:0] d);
    bus.in_valid = v;
    bus.data_in  = d;
    if (v && model_done && bus.mode == 2'b01) begin
      q.push_back('{model_eval(model_cfg, d), cyc + LAT});
    end
    step();
  endtask

  // A mode change loses every result that is not yet out.
  task automatic set_mode(input logic [1:0] m);
    bus.in_valid = 1'b0;
    if (bus.mode == 2'b01 && m != 2'b01) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    end
    if (m == 2'b00 && bus.mode != 2'b00) model_done = 1'b0;
    bus.mode = m;
  endtask

  task automatic serial_load(input logic [CFG_W-1:0] pat);
    for (int i = 0; i < CFG_W; i++) begin
      bus.config_en = 1'b1;
      bus.config_in = pat[i];
      step();
      if (i == CFG_W - 2) chk("done_after_55", {63'd0, bus.config_done}, 64'd0);
      if (i == CFG_W - 1) chk("done_after_56", {63'd0, bus.config_done}, 64'd1);
    end
    bus.config_en = 1'b0;
    model_cfg     = pat;
    model_done    = 1'b1;
  endtask

  // Monitor: match each valid output against the front of the scoreboard.
  always @(negedge clk) begin
    if (!clear) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL missing_output: got none by cycle %0d, expected %b due %0d", cyc, q[0].val, q[0].due);
        void'(q.pop_front());
      end
      if (bus.out_valid === 1'b1) begin
        exp_t e;
        checks = checks + 1;
        if (q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_valid: got out=%b at cycle %0d, expected no output", bus.out, cyc);
        end else begin
          e = q.pop_front();
          if (bus.out !== e.val || e.due != cyc) begin
            errors = errors + 1;
            $display("FAIL out_value: got %b at cycle %0d, expected %b at cycle %0d", bus.out, cyc, e.val, e.due);
          end
          last_out = e.val;
        end
      end
    end
  end

  localparam logic [CFG_W-1:0] SCAN_PAT = 56'hA5_C3F0_1234_5678;
  localparam logic [CFG_W-1:0] AND_OR   = {28'hEEEEEEE, 28'h8888888};

  initial begin
    logic [CFG_W-1:0] pat;
    logic             extra;
    cyc = 0; checks = 0; errors = 0;
    model_cfg = '0; model_done = 1'b0; last_out = '0;
    clear = 1'b0;
    bus.mode = 2'b11; bus.data_in = '0; bus.in_valid = 1'b0;
    bus.config_in = 1'b0; bus.config_en = 1'b0; bus.scan_in = '0; bus.scan_enable = 1'b0;

    // Assert reset mid-clock. The outputs must clear without a clock edge.
    #3 clear = 1'b1;
    #1;
    chk("rst_out",       {62'd0, bus.out},        64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid},  64'd0);
    chk("rst_done",      {63'd0, bus.config_done}, 64'd0);
    chk("rst_scan_out",  {8'd0, bus.scan_out},    64'd0);
    repeat (2) @(posedge clk);
    #2 clear = 1'b0;

    // USAGE before any config is loaded
    set_mode(2'b01);
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 8'hFF);
      chk("unconf_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("unconf_out",       {62'd0, bus.out},       64'd0);
    end

    // Parallel scan load, then readback
    set_mode(2'b00);
    step();
    bus.scan_enable = 1'b1; bus.scan_in = SCAN_PAT;
    step();
    bus.scan_enable = 1'b0;
    model_cfg = SCAN_PAT; model_done = 1'b1;
    chk("scan_done", {63'd0, bus.config_done}, 64'd1);
    set_mode(2'b10);
    bus.scan_enable = 1'b1;
    step();
    chk("scan_readback", {8'd0, bus.scan_out}, {8'd0, model_cfg});
    bus.scan_enable = 1'b0;
    step();
    chk("scan_out_idle", {8'd0, bus.scan_out}, 64'd0);

    // Serial load of a random pattern, one extra shift, then readback
    pat = {$urandom, $urandom};
    set_mode(2'b00);
    step();
    chk("reentry_done", {63'd0, bus.config_done}, 64'd0);
    serial_load(pat);
    extra = 1'($urandom_range(0, 1));
    bus.config_en = 1'b1; bus.config_in = extra;
    step();
    bus.config_en = 1'b0;
    model_cfg = {extra, model_cfg[CFG_W-1:1]};
    chk("overshift_done", {63'd0, bus.config_done}, 64'd1);
    set_mode(2'b10);
    bus.scan_enable = 1'b1;
    step();
    chk("serial_readback", {8'd0, bus.scan_out}, {8'd0, model_cfg});
    bus.scan_enable = 1'b0;

    // AND / OR trees
    set_mode(2'b00);
    step();
    bus.scan_enable = 1'b1; bus.scan_in = AND_OR;
    step();
    bus.scan_enable = 1'b0;
    model_cfg = AND_OR; model_done = 1'b1;
    set_mode(2'b01);
    issue(1'b1, 8'hFF);
    issue(1'b1, 8'h01);
    issue(1'b1, 8'h00);
    repeat (5) issue(1'b0, 8'h00);

    // Random config (serial) and random valid-qualified stream
    set_mode(2'b00);
    step();
    serial_load({$urandom, $urandom});
    set_mode(2'b01);
    for (int i = 0; i < 60; i++) begin
      issue($urandom_range(0, 3) != 0, 8'($urandom));
    end
    repeat (5) issue(1'b0, 8'h00);

    // Flush: leave USAGE while results are still in flight
    for (int i = 0; i < 4; i++) issue(1'b1, 8'($urandom));
    set_mode(2'b11);
    step();
    chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_out_hold",  {62'd0, bus.out},       {62'd0, last_out});
    step();
    chk("idle_out_hold",   {62'd0, bus.out},       {62'd0, last_out});

    // Reset mid-stream
    set_mode(2'b01);
    for (int i = 0; i < 3; i++) issue(1'b1, 8'($urandom));
    bus.in_valid = 1'b1;
    #1 clear = 1'b1;
    q.delete();
    model_cfg = '0; model_done = 1'b0; last_out = '0;
    #1;
    chk("midrst_out",       {62'd0, bus.out},         64'd0);
    chk("midrst_out_valid", {63'd0, bus.out_valid},   64'd0);
    chk("midrst_done",      {63'd0, bus.config_done}, 64'd0);
    repeat (2) @(posedge clk);
    #2 clear = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b1, 8'hFF);
    chk("post_rst_done", {63'd0, bus.config_done}, 64'd0);
    chk("post_rst_out",  {62'd0, bus.out},         64'd0);
    repeat (3) issue(1'b0, 8'h00);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
